// File: rtl/uart_seg7_core.sv
// 8N1 UART transmitter and receiver sharing one clock, plus a two-digit
// hex-to-seven-segment decoder for an 8-bit value.
module uart_seg7_core #(
    parameter int ClkFrequency = 11059200,
    parameter int Baud         = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_idle,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy,
    input  logic [7:0] number,
    output logic [7:0] seg_lo,
    output logic [7:0] seg_hi
);

    localparam int BitClks  = ClkFrequency / Baud;
    localparam int HalfClks = BitClks / 2;
    localparam int CntW     = (BitClks > 2) ? $clog2(BitClks) : 1;
    localparam logic [CntW-1:0] BitLast  = CntW'(BitClks - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfClks - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Segment pattern {dp,g,f,e,d,c,b,a} for one hex nibble; dp is always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'h3F;
            4'h1:    seg = 8'h06;
            4'h2:    seg = 8'h5B;
            4'h3:    seg = 8'h4F;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'h6D;
            4'h6:    seg = 8'h7D;
            4'h7:    seg = 8'h07;
            4'h8:    seg = 8'h7F;
            4'h9:    seg = 8'h6F;
            4'hA:    seg = 8'h77;
            4'hB:    seg = 8'h7C;
            4'hC:    seg = 8'h39;
            4'hD:    seg = 8'h5E;
            4'hE:    seg = 8'h79;
            4'hF:    seg = 8'h71;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    assign seg_lo = hex_to_seg(number[3:0]);
    assign seg_hi = hex_to_seg(number[7:4]);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic            tx_busy_q, tx_busy_d;
    logic            txd_q, txd_d;
    logic [8:0]      tx_shift_q, tx_shift_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic            tx_accept_s;
    logic            tx_tick_s;

    assign tx_accept_s = TxD_start & ~tx_busy_q;
    assign tx_tick_s   = (tx_cnt_q == BitLast);

    // Transmit next-state: start bit is driven on acceptance, the shift register holds data plus stop.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        txd_d      = txd_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        if (tx_accept_s) begin
            tx_busy_d  = 1'b1;
            txd_d      = 1'b0;
            tx_shift_d = {1'b1, TxD_data};
            tx_cnt_d   = '0;
            tx_bit_d   = 4'd0;
        end else if (tx_busy_q) begin
            if (tx_tick_s) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    txd_d     = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 4'd1;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                end
            end else begin
                tx_cnt_d = tx_cnt_q + CntW'(1);
            end
        end else begin
            txd_d = 1'b1;
        end
    end

    // Transmit state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            txd_q      <= 1'b1;
            tx_shift_q <= 9'h1FF;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 4'd0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            txd_q      <= txd_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    assign TxD      = txd_q;
    assign TxD_busy = tx_busy_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_e       rx_state_q, rx_state_d;
    logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_ready_q, rx_ready_d;
    logic            rx_idle_q;
    logic            rx_fall_s, rx_half_s, rx_tick_s;

    assign rx_fall_s = rx_prev_q & ~rx_sync2_q;
    assign rx_half_s = (rx_cnt_q == HalfLast);
    assign rx_tick_s = (rx_cnt_q == BitLast);

    // Line synchroniser; the third stage only serves falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= RxD;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    // Receiver next-state: a high mid-start sample is treated as a glitch.
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall_s) rx_state_d = RX_START;
                else           rx_state_d = RX_IDLE;
            end
            RX_START: begin
                if (rx_half_s) rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                else           rx_state_d = RX_START;
            end
            RX_DATA: begin
                if (rx_tick_s && (rx_bit_q == 3'd7)) rx_state_d = RX_STOP;
                else                                 rx_state_d = RX_DATA;
            end
            RX_STOP: begin
                if (rx_tick_s) rx_state_d = RX_IDLE;
                else           rx_state_d = RX_STOP;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver datapath: bit timing, LSB-first shift, and stop-bit qualified update.
    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_ready_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = 3'd0;
            end
            RX_START: begin
                if (rx_half_s) rx_cnt_d = '0;
                else           rx_cnt_d = rx_cnt_q + CntW'(1);
            end
            RX_DATA: begin
                if (rx_tick_s) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            RX_STOP: begin
                if (rx_tick_s) begin
                    rx_cnt_d = '0;
                    if (rx_sync2_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_ready_d = 1'b1;
                    end else begin
                        rx_data_d  = rx_data_q;
                        rx_ready_d = 1'b0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            default: begin
                rx_cnt_d = '0;
                rx_bit_d = 3'd0;
            end
        endcase
    end

    // Receiver datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
            rx_idle_q  <= 1'b1;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_ready_q <= rx_ready_d;
            rx_idle_q  <= (rx_state_d == RX_IDLE);
        end
    end

    assign RxD_data       = rx_data_q;
    assign RxD_data_ready = rx_ready_q;
    assign RxD_idle       = rx_idle_q;

endmodule

// File: tb/tb_uart_seg7_core.sv
// Scoreboard bench for uart_seg7_core: directed TX/RX frames, loopback,
// glitch/framing cases, reset abort and segment decode.
module tb_uart_seg7_core;

    localparam int BitClks = 96;

    logic       clk;
    logic       rst_n;
    logic       rx_drv;
    logic       loop_en;
    logic       rxd_w;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_idle;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       TxD;
    logic       TxD_busy;
    logic [7:0] number;
    logic [7:0] seg_lo;
    logic [7:0] seg_hi;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    assign rxd_w = loop_en ? TxD : rx_drv;

    uart_seg7_core #(.ClkFrequency(11059200), .Baud(115200)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RxD            (rxd_w),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_idle       (RxD_idle),
        .TxD_start      (TxD_start),
        .TxD_data       (TxD_data),
        .TxD            (TxD),
        .TxD_busy       (TxD_busy),
        .number         (number),
        .seg_lo         (seg_lo),
        .seg_hi         (seg_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Protocol-level monitor: decodes TxD frames, measures busy length, takes RX pulses.
    task automatic monitor_loop();
        int         tx_st    = 0;
        int         tx_cnt   = 0;
        int         busy_run = 0;
        logic [9:0] tx_bits  = '0;
        logic       rdy_prev = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_st    = 0;
                busy_run = 0;
                rdy_prev = 1'b0;
            end else begin
                if (tx_st == 0) begin
                    if (TxD === 1'b0) begin
                        tx_st  = 1;
                        tx_cnt = 1;
                    end
                end else begin
                    tx_cnt++;
                    if ((tx_cnt % BitClks) == BitClks / 2) begin
                        tx_bits[tx_cnt / BitClks] = TxD;
                        if (tx_cnt / BitClks == 9) begin
                            tx_st = 0;
                            checks++;
                            if (tx_exp.size() == 0) begin
                                failures++;
                                $display("FAIL tx_frame: unexpected frame %0h", tx_bits[8:1]);
                            end else begin
                                checks--;
                                e = tx_exp.pop_front();
                                chk("tx_byte", int'(tx_bits[8:1]), int'(e));
                                chk("tx_start_stop", int'({tx_bits[9], tx_bits[0]}), 2);
                            end
                        end
                    end
                end

                if (TxD_busy) begin
                    busy_run++;
                end else if (busy_run != 0) begin
                    chk("tx_busy_len", busy_run, 10 * BitClks);
                    busy_run = 0;
                end

                if (RxD_data_ready) begin
                    if (rdy_prev) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_ready_width: pulse longer than 1 cycle got 2 expected 1");
                    end else if (rx_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_pulse: unexpected pulse data %0h", RxD_data);
                    end else begin
                        e = rx_exp.pop_front();
                        chk("rx_byte", int'(RxD_data), int'(e));
                    end
                end
                rdy_prev = RxD_data_ready;
            end
        end
    endtask

    task automatic pulse_tx(input logic [7:0] d);
        @(negedge clk);
        TxD_data  = d;
        TxD_start = 1'b1;
        @(negedge clk);
        TxD_start = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (TxD_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_idle_timeout", int'(TxD_busy), 0);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (BitClks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BitClks) @(negedge clk);
            if (i == 2) chk("rx_idle_in_frame", int'(RxD_idle), 0);
        end
        rx_drv = stop;
        repeat (BitClks) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    logic [23:0] seg_vec [7];

    initial begin
        int n;
        int bad;
        seg_vec = '{24'h7E_07_79, 24'h00_3F_3F, 24'hB4_7C_66, 24'hC9_39_6F,
                    24'hD8_5E_7F, 24'hF1_71_06, 24'hA2_77_5B};
        rst_n     = 1'b0;
        rx_drv    = 1'b1;
        loop_en   = 1'b0;
        TxD_start = 1'b0;
        TxD_data  = 8'h00;
        number    = 8'h7E;
        fork
            monitor_loop();
        join_none

        repeat (5) @(negedge clk);
        chk("rst_txd", int'(TxD), 1);
        chk("rst_busy", int'(TxD_busy), 0);
        chk("rst_rx_data", int'(RxD_data), 0);
        chk("rst_rx_ready", int'(RxD_data_ready), 0);
        chk("rst_rx_idle", int'(RxD_idle), 1);
        chk("rst_seg_hi", int'(seg_hi), 8'h07);
        chk("rst_seg_lo", int'(seg_lo), 8'h79);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            number = seg_vec[i][23:16];
            #1;
            chk("seg_hi", int'(seg_hi), int'(seg_vec[i][15:8]));
            chk("seg_lo", int'(seg_lo), int'(seg_vec[i][7:0]));
        end

        // TX A5: start-bit length, busy the cycle after acceptance, ignored start while busy
        tx_exp.push_back(8'hA5);
        pulse_tx(8'hA5);
        chk("tx_busy_after_accept", int'(TxD_busy), 1);
        n = 0;
        while (TxD === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("tx_start_len", n, BitClks);
        TxD_data  = 8'h00;
        TxD_start = 1'b1;
        @(negedge clk);
        TxD_start = 1'b0;
        wait_tx_idle();
        repeat (5) @(negedge clk);
        chk("tx_idle_line", int'(TxD), 1);

        // back-to-back with TxD_start held high
        tx_exp.push_back(8'h81);
        tx_exp.push_back(8'h42);
        @(negedge clk);
        TxD_data  = 8'h81;
        TxD_start = 1'b1;
        @(negedge clk);
        TxD_data = 8'h42;
        wait_tx_idle();
        n = 0;
        while (!TxD_busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        TxD_start = 1'b0;
        chk("tx_b2b_gap", n, 1);
        wait_tx_idle();
        repeat (5) @(negedge clk);

        // RX good frame, framing error, glitch
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        chk("rx_data_3c", int'(RxD_data), 8'h3C);
        chk("rx_idle_after", int'(RxD_idle), 1);
        send_rx(8'h99, 1'b0);
        repeat (100) @(negedge clk);
        chk("rx_frame_err_data", int'(RxD_data), 8'h3C);
        chk("rx_frame_err_idle", int'(RxD_idle), 1);
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (150) @(negedge clk);
        chk("rx_glitch_idle", int'(RxD_idle), 1);
        chk("rx_glitch_data", int'(RxD_data), 8'h3C);

        // loopback
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'h00 : ((i == 1) ? 8'hFF : 8'h55);
            tx_exp.push_back(b);
            rx_exp.push_back(b);
            pulse_tx(b);
            wait_tx_idle();
            repeat (20) @(negedge clk);
        end
        chk("loop_rx_pending", rx_exp.size(), 0);
        chk("loop_rx_last", int'(RxD_data), 8'h55);
        loop_en = 1'b0;
        repeat (5) @(negedge clk);

        // reset mid-transmit
        pulse_tx(8'h12);
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_txd", int'(TxD), 1);
        chk("abort_busy", int'(TxD_busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || TxD_busy !== 1'b0) bad++;
        end
        chk("abort_stays_idle", bad, 0);

        // recovery frame through loopback
        loop_en = 1'b1;
        tx_exp.push_back(8'hC3);
        rx_exp.push_back(8'hC3);
        pulse_tx(8'hC3);
        wait_tx_idle();
        repeat (30) @(negedge clk);
        chk("final_tx_pending", tx_exp.size(), 0);
        chk("final_rx_pending", rx_exp.size(), 0);
        chk("final_rx_data", int'(RxD_data), 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_seg7_core.md
UART_SEG7_CORE -- requirements
Module: uart_seg7_core

Interface
REQ-001 SHALL have parameter ClkFrequency, default 11059200, clk frequency in Hz.
REQ-002 SHALL have parameter Baud, default 115200, serial bit rate; BIT_CLKS = ClkFrequency/Baud (integer, 96 at defaults).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock for all logic.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port RxD, input, 1 bit, serial receive line, idle high, asynchronous to clk.
REQ-007 SHALL have port RxD_data, output, 8 bits, last received byte.
REQ-008 SHALL have port RxD_data_ready, output, 1 bit, one-cycle pulse when RxD_data updates.
REQ-009 SHALL have port RxD_idle, output, 1 bit, high while the receiver is not inside a frame.
REQ-010 SHALL have port TxD_start, input, 1 bit, transmit request.
REQ-011 SHALL have port TxD_data, input, 8 bits, byte to transmit.
REQ-012 SHALL have port TxD, output, 1 bit, serial transmit line.
REQ-013 SHALL have port TxD_busy, output, 1 bit, high while a frame is being sent.
REQ-014 SHALL have port number, input, 8 bits, value to display as two hex digits.
REQ-015 SHALL have port seg_lo, output, 8 bits, segments for number[3:0], ordered {dp,g,f,e,d,c,b,a}, active-high.
REQ-016 SHALL have port seg_hi, output, 8 bits, segments for number[7:4], same encoding as seg_lo.

Function
REQ-017 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts BIT_CLKS cycles.
REQ-018 Transmitter SHALL accept TxD_start only when TxD_busy=0, latching TxD_data on that edge.
REQ-019 TxD_busy SHALL go high on the cycle after acceptance and stay high until the stop bit has lasted BIT_CLKS cycles, i.e. 10*BIT_CLKS cycles total (960 at defaults).
REQ-020 TxD_start while busy SHALL be ignored; TxD_data changes while busy SHALL NOT alter the frame.
REQ-021 TxD SHALL drive 1 whenever the transmitter is idle; TxD_start held high continuously SHALL send back-to-back frames with no extra idle bit.
REQ-022 Receiver SHALL synchronise RxD through two flip-flops before use.
REQ-023 Receiver states SHALL be IDLE, START, DATA, STOP. A falling synchronised RxD in IDLE SHALL enter START.
REQ-024 In START, RxD SHALL be sampled at BIT_CLKS/2; if 1 (glitch) the receiver SHALL return to IDLE, else it SHALL enter DATA.
REQ-025 DATA bits SHALL be sampled every BIT_CLKS cycles after the mid-start sample and shifted in LSB first.
REQ-026 In STOP, the sampled bit SHALL be tested: if 1, RxD_data SHALL be updated and RxD_data_ready pulsed for exactly one cycle; if 0 (framing error), data SHALL be discarded with no pulse and RxD_data unchanged. Either way the receiver SHALL return to IDLE.
REQ-027 RxD_idle SHALL be 1 only in IDLE.
REQ-028 Segment decode SHALL be combinational; dp SHALL always be 0; hex codes {g..a} SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-029 Receiver and transmitter SHALL operate independently and simultaneously.

Reset
REQ-030 While rst_n=0: TxD=1, TxD_busy=0, RxD_data=8'h00, RxD_data_ready=0, RxD_idle=1; all counters and both state machines are in idle.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; after release the transmitter SHALL wait for a new TxD_start, and the receiver SHALL wait for a new falling edge.
REQ-032 Segment outputs SHALL follow number regardless of rst_n.

Verification
REQ-033 Pulse TxD_start with TxD_data=8'hA5 -> TxD low for 96 clocks, then bits 1,0,1,0,0,1,0,1 at 96 clocks each, then high; TxD_busy high for 960 clocks.
REQ-034 Drive a 96-clock/bit RxD frame carrying 8'h3C -> single-cycle RxD_data_ready; RxD_data=8'h3C; RxD_idle low during the frame.
REQ-035 Send a RxD frame with stop bit 0 -> no RxD_data_ready pulse; RxD_data keeps its previous value.
REQ-036 Drive a 20-clock low glitch on RxD -> receiver returns to IDLE with no pulse.
REQ-037 Loop TxD to RxD and send 8'h00, 8'hFF, 8'h55 -> each byte is received intact.
REQ-038 Set number=8'h7E -> seg_hi=8'h07 and seg_lo=8'h79; assert rst_n=0 mid-transmit -> TxD=1 and TxD_busy=0 immediately.
